mul_ctrl: RTL and testbench

MUL_CTRL -- requirements
Module: mul_ctrl

---
 rtl/mul_ctrl_pkg.sv | 24 ++
 rtl/mul_ctrl_if.sv | 31 +++
 rtl/mul_sign_fix.sv | 43 ++++
 rtl/mul_ctrl.sv | 98 +++++++++
 tb/tb_mul_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg
//   Shared definitions for the multiply controller: datapath width,
//   destination-tag width, funct3 encodings and FSM state enumeration.
package mul_ctrl_pkg;

    localparam int MC_XLEN = 32;
    localparam int MC_RD_W = 5;

    typedef enum logic [2:0] {
        F_MUL    = 3'b000,
        F_MULH   = 3'b001,
        F_MULHSU = 3'b010,
        F_MULHU  = 3'b011
    } funct3_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if
//   Request/response handshake bundle of the multiply controller.
//   Request : in_valid, in_ready, in_funct3, in_rs1, in_rs2, in_rd
//   Response: out_valid, out_ready, out_result, out_rd
//   master = requester/consumer side, slave = mul_ctrl side.
interface mul_ctrl_if;
    import mul_ctrl_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_funct3;
    logic [MC_XLEN-1:0]   in_rs1;
    logic [MC_XLEN-1:0]   in_rs2;
    logic [MC_RD_W-1:0]   in_rd;

    logic                 out_valid;
    logic                 out_ready;
    logic [MC_XLEN-1:0]   out_result;
    logic [MC_RD_W-1:0]   out_rd;

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs2, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd
    );

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs2, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd
    );

endinterface

// File: rtl/mul_sign_fix.sv
// mul_sign_fix
//   Turns the signed 2*XLEN product of the shared signed multiplier into the
//   RISC-V M result selected by funct3.
//   mul_p  : signed product of rs1 x rs2
//   rs1/rs2: original operands
//   funct3 : 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, others -> MUL
//   result : XLEN-bit result
module mul_sign_fix
    import mul_ctrl_pkg::*;
#(
    parameter int XLEN = MC_XLEN
) (
    input  logic [2*XLEN-1:0] mul_p,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [2:0]        funct3,
    output logic [XLEN-1:0]   result
);

    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] fix_rs2_neg;
    logic [XLEN-1:0] fix_rs1_neg;

    assign hi = mul_p[2*XLEN-1:XLEN];
    assign lo = mul_p[XLEN-1:0];

    // Reinterpreting a negative signed operand as unsigned adds 2^XLEN times
    // the other operand to the product, i.e. that operand to the high word.
    assign fix_rs2_neg = rs2[XLEN-1] ? rs1 : '0;
    assign fix_rs1_neg = rs1[XLEN-1] ? rs2 : '0;

    always_comb begin
        result = lo;
        case (funct3)
            F_MULH:   result = hi;
            F_MULHSU: result = hi + fix_rs2_neg;
            F_MULHU:  result = hi + fix_rs2_neg + fix_rs1_neg;
            default:  result = lo;
        endcase
    end

endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl
//   Sequences one multiply at a time through an external signed multiplier
//   with fixed 2-cycle latency and applies the funct3 sign correction.
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset (priority over flush and accept)
//   bus   : request/response handshake (mul_ctrl_if slave)
//   flush : drop any in-flight or pending operation
//   mul_x : multiplier operand (latched rs1)
//   mul_y : multiplier operand (latched rs2)
//   mul_p : signed product, valid while in S3
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int XLEN = MC_XLEN
) (
    input  logic              CLK,
    input  logic              RST,
    mul_ctrl_if.slave         bus,
    input  logic              flush,
    output logic [XLEN-1:0]   mul_x,
    output logic [XLEN-1:0]   mul_y,
    input  logic [2*XLEN-1:0] mul_p
);

    state_e               state_q;
    state_e               state_d;
    logic [XLEN-1:0]      rs1_q;
    logic [XLEN-1:0]      rs2_q;
    logic [2:0]           funct3_q;
    logic [MC_RD_W-1:0]   rd_q;
    logic [XLEN-1:0]      result_q;
    logic [MC_RD_W-1:0]   out_rd_q;
    logic [XLEN-1:0]      fixed_result;
    logic                 accept;

    assign bus.in_ready = ((state_q == ST_IDLE) ||
                           (state_q == ST_DONE && bus.out_ready)) && !flush;
    assign accept       = bus.in_valid && bus.in_ready;

    assign mul_x          = rs1_q;
    assign mul_y          = rs2_q;
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_result = result_q;
    assign bus.out_rd     = out_rd_q;

    mul_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .mul_p  (mul_p),
        .rs1    (rs1_q),
        .rs2    (rs2_q),
        .funct3 (funct3_q),
        .result (fixed_result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2:   state_d = ST_S3;
            ST_S3:   state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = accept ? ST_S1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Operands only change on accept, so mul_x/mul_y stay stable for the
    // whole operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rs1_q    <= '0;
            rs2_q    <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
        end else if (accept) begin
            rs1_q    <= bus.in_rs1;
            rs2_q    <= bus.in_rs2;
            funct3_q <= bus.in_funct3;
            rd_q     <= bus.in_rd;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            result_q <= '0;
            out_rd_q <= '0;
        end else if (state_q == ST_S3 && !flush) begin
            result_q <= fixed_result;
            out_rd_q <= rd_q;
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
module tb_mul_ctrl;
    import mul_ctrl_pkg::*;

    localparam int NOPS = 10000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] mul_x, mul_y;
    logic [63:0] mul_p;
    logic signed [63:0] p1, p2;

    int checks = 0;
    int failures = 0;

    mul_ctrl_if bus();

    mul_ctrl #(.XLEN(32)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .bus   (bus.slave),
        .flush (flush),
        .mul_x (mul_x),
        .mul_y (mul_y),
        .mul_p (mul_p)
    );

    always #5 CLK = ~CLK;

    // Environment multiplier: signed product, two registered stages.
    always @(posedge CLK) begin
        if (RST) begin
            p1 <= '0;
            p2 <= '0;
        end else begin
            p1 <= $signed(mul_x) * $signed(mul_y);
            p2 <= p1;
        end
    end
    assign mul_p = p2;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference: mathematical product of the operands interpreted per funct3.
    function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     full;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'b001:  begin full = sa * sb;          return full[63:32]; end
            3'b010:  begin full = sa * longint'(ub); return full[63:32]; end
            3'b011:  begin full = ua * ub;          return full[63:32]; end
            default: begin full = ua * ub;          return full[31:0];  end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.in_valid  = 1'b1;
        bus.in_funct3 = f;
        bus.in_rs1    = a;
        bus.in_rs2    = b;
        bus.in_rd     = rd;
    endtask

    // Wait for out_valid after an accept edge; returns edges counted.
    task automatic wait_valid(output int k);
        k = 0;
        while (!bus.out_valid && k < 12) begin
            step();
            k++;
        end
    endtask

    // One complete operation from IDLE, checked for latency and value.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int k;
        bus.out_ready = 1'b1;
        drive_req(f, a, b, rd);
        #1;
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_mulx"}, mul_x, a);
        chk({tag, "_muly"}, mul_y, b);
        wait_valid(k);
        chk({tag, "_latency"}, k, 3);
        chk({tag, "_result"}, bus.out_result, exp);
        chk({tag, "_model"}, bus.out_result, ref_mul(f, a, b));
        chk({tag, "_rd"}, bus.out_rd, rd);
        step();
        chk({tag, "_valid_drop"}, bus.out_valid, 0);
    endtask

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    initial begin
        exp_t        q[$];
        int          k;
        int          edge_n;
        int          done_ops;
        logic        exp_valid, exp_ready, acc, hs;
        logic [31:0] a, b, held_res;
        logic [2:0]  f;
        logic [4:0]  rd;

        bus.in_valid  = 1'b0;
        bus.in_funct3 = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_rd     = '0;
        bus.out_ready = 1'b0;

        // Reset
        RST = 1'b1;
        step();
        step();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_result", bus.out_result, 0);
        chk("rst_rd", bus.out_rd, 0);
        chk("rst_mulx", mul_x, 0);
        chk("rst_muly", mul_y, 0);
        RST = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // Corner values
        run_op("mulhu_ff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE);
        run_op("mul_ff",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000001);
        run_op("mulh_ff",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000000);
        run_op("mulhsu_ff",3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF);
        run_op("mulh_80",  3'b001, 32'h80000000, 32'h80000000, 5'd5, 32'h40000000);
        run_op("mulhu_80", 3'b011, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000);
        run_op("f3_other", 3'b110, 32'h12345678, 32'h00000010, 5'd7, 32'h23456780);
        run_op("mulhsu_mix", 3'b010, 32'h80000000, 32'h00000002, 5'd8, 32'hFFFFFFFF);

        // Back-to-back: second request accepted on the DONE handshake edge
        bus.out_ready = 1'b1;
        drive_req(3'b000, 32'd7, 32'd6, 5'd9);
        step();
        bus.in_valid = 1'b0;
        wait_valid(k);
        chk("b2b_a_latency", k, 3);
        chk("b2b_a_result", bus.out_result, 42);
        drive_req(3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd10);
        #1;
        chk("b2b_in_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("b2b_gap", bus.out_valid, 0);
        chk("b2b_b_mulx", mul_x, 32'h7FFFFFFF);
        wait_valid(k);
        chk("b2b_b_latency", k, 3);
        chk("b2b_b_result", bus.out_result, 32'h3FFFFFFF);
        chk("b2b_b_rd", bus.out_rd, 10);
        step();

        // Consumer stall for 10 cycles in DONE
        bus.out_ready = 1'b0;
        drive_req(3'b011, 32'hDEADBEEF, 32'hCAFEF00D, 5'd17);
        step();
        bus.in_valid = 1'b0;
        wait_valid(k);
        held_res = ref_mul(3'b011, 32'hDEADBEEF, 32'hCAFEF00D);
        for (int i = 0; i < 10; i++) begin
            drive_req(3'b000, $urandom, $urandom, 5'd30);
            #1;
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_result", bus.out_result, held_res);
            chk("stall_rd", bus.out_rd, 17);
            chk("stall_mulx", mul_x, 32'hDEADBEEF);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("stall_release", bus.out_valid, 0);

        // Flush in S2 together with a new request
        drive_req(3'b000, 32'd3, 32'd5, 5'd11);
        step();
        bus.in_valid = 1'b0;
        step();
        flush = 1'b1;
        drive_req(3'b000, 32'd100, 32'd200, 5'd12);
        #1;
        chk("flush_s2_in_ready", bus.in_ready, 0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_s2_idle", bus.in_ready, 1);
        chk("flush_s2_no_accept", mul_x, 3);
        for (int i = 0; i < 5; i++) begin
            chk("flush_s2_valid", bus.out_valid, 0);
            step();
        end
        run_op("after_flush", 3'b001, 32'hFFFFFFFE, 32'h00000003, 5'd13, 32'hFFFFFFFF);

        // Flush while the result is pending in DONE
        bus.out_ready = 1'b0;
        drive_req(3'b000, 32'd9, 32'd9, 5'd14);
        step();
        bus.in_valid = 1'b0;
        wait_valid(k);
        chk("flush_done_valid_before", bus.out_valid, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("flush_done_dropped", bus.out_valid, 0);
            step();
        end

        // Reset while in S3
        bus.out_ready = 1'b1;
        drive_req(3'b011, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd21);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        RST = 1'b1;
        step();
        chk("rst_s3_valid", bus.out_valid, 0);
        chk("rst_s3_result", bus.out_result, 0);
        chk("rst_s3_rd", bus.out_rd, 0);
        chk("rst_s3_mulx", mul_x, 0);
        chk("rst_s3_muly", mul_y, 0);
        chk("rst_s3_idle", bus.in_ready, 1);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_s3_no_output", bus.out_valid, 0);
            step();
        end

        // Randomized run against the reference model
        edge_n   = 0;
        done_ops = 0;
        while (done_ops < NOPS && edge_n < 90000) begin
            exp_valid = (q.size() != 0) && (edge_n >= q[0].due);
            chk("rnd_valid", bus.out_valid, exp_valid);
            if (exp_valid) begin
                chk("rnd_result", bus.out_result, q[0].res);
                chk("rnd_rd", bus.out_rd, q[0].rd);
            end
            f  = 3'($urandom_range(7));
            rd = 5'($urandom);
            case ($urandom_range(7))
                0:       a = 32'h80000000;
                1:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(7))
                0:       b = 32'h80000000;
                1:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            drive_req(f, a, b, rd);
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.out_ready = ($urandom_range(3) != 0);
            #1;
            exp_ready = (q.size() == 0) || (exp_valid && bus.out_ready);
            chk("rnd_in_ready", bus.in_ready, exp_ready);
            hs  = exp_valid && bus.out_ready;
            acc = bus.in_valid && exp_ready;
            @(posedge CLK);
            edge_n++;
            if (hs) begin
                void'(q.pop_front());
                done_ops++;
            end
            if (acc) q.push_back('{ref_mul(f, a, b), rd, edge_n + 3});
            @(negedge CLK);
        end
        bus.in_valid = 1'b0;
        chk("rnd_ops_completed", done_ops, NOPS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
